// File: rtl/wm8978_i2c_arb_if.sv
// Request/response bundle between the two WM8978 control clients, the
// arbiter and the shared I2C master. "slave" is the arbiter's view,
// "master" is the view of whatever drives the clients and the I2C side.
interface wm8978_i2c_arb_if;
    logic        r0_exec;
    logic [15:0] r0_data;
    logic        r0_done;
    logic        r0_err;
    logic        r1_exec;
    logic [15:0] r1_data;
    logic        r1_done;
    logic        r1_err;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        i2c_done;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  ovf;

    modport slave (
        input  r0_exec, r0_data, r1_exec, r1_data, i2c_done,
        output r0_done, r0_err, r1_done, r1_err,
        output i2c_exec, i2c_data, grant, busy, ovf
    );

    modport master (
        output r0_exec, r0_data, r1_exec, r1_data, i2c_done,
        input  r0_done, r0_err, r1_done, r1_err,
        input  i2c_exec, i2c_data, grant, busy, ovf
    );
endinterface

// File: rtl/wm8978_i2c_arb.sv
// Two-port round-robin arbiter in front of a single WM8978 I2C write master.
// Each port can hold one outstanding 16-bit register write; extra requests
// while a port is still pending are dropped and flagged in ovf. A WAIT-state
// watchdog aborts a transaction that never sees i2c_done.
module wm8978_i2c_arb #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                  clk,
    input  logic                  rst,
    wm8978_i2c_arb_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  pend_reg;
    logic [15:0] hold_reg [2];
    logic [1:0]  done_reg;
    logic [1:0]  err_reg;
    logic [1:0]  grant_reg;
    logic [1:0]  ovf_reg;
    logic        last_reg;       // 1 = port 1 was granted last
    logic        i2c_exec_reg;
    logic [15:0] i2c_data_reg;
    logic [15:0] cnt_reg;

    logic [1:0]  exec_w;
    logic [15:0] data_w [2];
    logic [1:0]  accept_w;
    logic [1:0]  drop_w;
    logic [1:0]  elig_w;
    logic        win_w;
    logic        timeout_w;

    assign exec_w = {bus.r1_exec, bus.r0_exec};

    // Per-port request qualification. A port whose done pulse is on the
    // outputs still has its pending bit set for this edge (so a re-request in
    // that cycle is dropped), but it must not be re-granted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            assign data_w[gi]   = (gi == 0) ? bus.r0_data : bus.r1_data;
            assign accept_w[gi] = exec_w[gi] & ~pend_reg[gi];
            assign drop_w[gi]   = exec_w[gi] &  pend_reg[gi];
            assign elig_w[gi]   = pend_reg[gi] & ~done_reg[gi];
        end
    endgenerate

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        win_w = 1'b0;
        if (elig_w == 2'b11) begin
            win_w = ~last_reg;
        end else begin
            win_w = elig_w[1];
        end
    end

    assign timeout_w = (TIMEOUT != 16'd0) && (cnt_reg == TIMEOUT - 16'd1);

    // Request capture, arbitration FSM, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pend_reg     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                hold_reg[i] <= 16'd0;
            end
            done_reg     <= 2'b00;
            err_reg      <= 2'b00;
            grant_reg    <= 2'b00;
            ovf_reg      <= 2'b00;
            last_reg     <= 1'b1;
            i2c_exec_reg <= 1'b0;
            i2c_data_reg <= 16'd0;
            cnt_reg      <= 16'd0;
        end else begin
            done_reg     <= 2'b00;
            err_reg      <= 2'b00;
            i2c_exec_reg <= 1'b0;

            for (int i = 0; i < 2; i++) begin
                if (done_reg[i]) begin
                    pend_reg[i] <= 1'b0;
                end
                if (accept_w[i]) begin
                    pend_reg[i] <= 1'b1;
                    hold_reg[i] <= data_w[i];
                end
                if (drop_w[i]) begin
                    ovf_reg[i] <= 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (elig_w != 2'b00) begin
                        grant_reg    <= win_w ? 2'b10 : 2'b01;
                        last_reg     <= win_w;
                        i2c_data_reg <= hold_reg[win_w];
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    i2c_exec_reg <= 1'b1;
                    cnt_reg      <= 16'd0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i2c_done) begin
                        done_reg  <= grant_reg;
                        grant_reg <= 2'b00;
                        state_reg <= ST_IDLE;
                    end else if (timeout_w) begin
                        done_reg  <= grant_reg;
                        err_reg   <= grant_reg;
                        grant_reg <= 2'b00;
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg != 16'hFFFF) begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.r0_done  = done_reg[0];
    assign bus.r0_err   = err_reg[0];
    assign bus.r1_done  = done_reg[1];
    assign bus.r1_err   = err_reg[1];
    assign bus.i2c_exec = i2c_exec_reg;
    assign bus.i2c_data = i2c_data_reg;
    assign bus.grant    = grant_reg;
    assign bus.ovf      = ovf_reg;
    assign bus.busy     = (state_reg != ST_IDLE) | (|pend_reg);

endmodule

// File: tb/tb_wm8978_i2c_arb.sv
// Bench for wm8978_i2c_arb: directed scenarios followed by random traffic,
// with a transaction-timing reference model feeding expected-event queues
// that a negedge monitor consumes.
module tb_wm8978_i2c_arb;

    localparam logic [15:0] TO = 16'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wm8978_i2c_arb_if bus();

    wm8978_i2c_arb #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [15:0] data;
        int          cyc;
        bit          err;
    } ev_t;

    ev_t exec_q[$];
    ev_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int resp_fixed = -2;      // -2 random delay, -1 never answer, >=0 fixed delay
    bit spur_en = 1'b0;

    // Reference model state (meaning: values valid during the current cycle)
    bit          m_pend [2];
    logic [15:0] m_hold [2];
    int          m_done_cyc [2];
    bit          m_last;
    bit          m_active;
    int          m_owner;
    int          m_exec_cyc;
    logic [1:0]  m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference model: a request is accepted when its port holds nothing;
    // the port stays pending up to and including the cycle of its done pulse.
    // A free master grants at the next edge, strobes the I2C master two
    // cycles after the grant decision, and finishes one cycle after i2c_done
    // or after TO cycles spent waiting.
    initial begin
        m_last = 1'b1;
        m_active = 1'b0;
        m_owner = 0;
        m_exec_cyc = 0;
        m_ovf = 2'b00;
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 1'b0;
            m_hold[p] = 16'd0;
            m_done_cyc[p] = -1;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_last = 1'b1;
                m_active = 1'b0;
                m_ovf = 2'b00;
                for (int p = 0; p < 2; p++) begin
                    m_pend[p] = 1'b0;
                    m_hold[p] = 16'd0;
                    m_done_cyc[p] = -1;
                end
                exec_q.delete();
                done_q.delete();
            end else begin
                bit          ex [2];
                logic [15:0] dt [2];
                bit          el [2];
                ex[0] = bus.r0_exec;  dt[0] = bus.r0_data;
                ex[1] = bus.r1_exec;  dt[1] = bus.r1_data;
                for (int p = 0; p < 2; p++) begin
                    el[p] = m_pend[p] && (m_done_cyc[p] != cyc);
                end
                if (!m_active && (el[0] || el[1])) begin
                    int w;
                    ev_t e;
                    if (el[0] && el[1]) w = m_last ? 0 : 1;
                    else                w = el[1] ? 1 : 0;
                    m_active = 1'b1;
                    m_owner = w;
                    m_last = (w == 1);
                    m_exec_cyc = cyc + 2;
                    e.port = w; e.data = m_hold[w]; e.cyc = cyc + 2; e.err = 1'b0;
                    exec_q.push_back(e);
                end else if (m_active && cyc >= m_exec_cyc) begin
                    bit fin, er;
                    fin = 1'b0; er = 1'b0;
                    if (bus.i2c_done === 1'b1) begin
                        fin = 1'b1;
                    end else if (TO != 16'd0 && (cyc - m_exec_cyc) == int'(TO) - 1) begin
                        fin = 1'b1; er = 1'b1;
                    end
                    if (fin) begin
                        ev_t e;
                        e.port = m_owner; e.data = 16'd0; e.cyc = cyc + 1; e.err = er;
                        done_q.push_back(e);
                        m_done_cyc[m_owner] = cyc + 1;
                        m_active = 1'b0;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    bit was;
                    was = m_pend[p];
                    if (ex[p]) begin
                        if (was) begin
                            m_ovf[p] = 1'b1;
                        end else begin
                            m_pend[p] = 1'b1;
                            m_hold[p] = dt[p];
                        end
                    end
                    if (was && m_done_cyc[p] == cyc) m_pend[p] = 1'b0;
                end
            end
            cyc++;
        end
    end

    // I2C master stand-in: answers each strobe with i2c_done after a delay.
    initial begin
        int cd;
        cd = -1;
        bus.i2c_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.i2c_done = 1'b0;
            if (bus.i2c_exec === 1'b1) begin
                cd = (resp_fixed == -2) ? int'($urandom_range(0, 11)) : resp_fixed;
            end
            if (cd == 0) bus.i2c_done = 1'b1;
            if (cd >= 0) cd--;
            if (spur_en && $urandom_range(0, 40) == 0) bus.i2c_done = 1'b1;
        end
    end

    // Monitor: pops expected events whenever the DUT presents one.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                logic [1:0] dn, er;
                while (exec_q.size() != 0 && exec_q[0].cyc < cyc) begin
                    check("exec_missing_cycle", cyc, exec_q[0].cyc);
                    void'(exec_q.pop_front());
                end
                while (done_q.size() != 0 && done_q[0].cyc < cyc) begin
                    check("done_missing_cycle", cyc, done_q[0].cyc);
                    void'(done_q.pop_front());
                end
                if (bus.i2c_exec === 1'b1) begin
                    if (exec_q.size() == 0) begin
                        check("exec_spurious", bus.i2c_exec, 0);
                    end else begin
                        ev_t e;
                        e = exec_q.pop_front();
                        check("exec_cycle", cyc, e.cyc);
                        check("exec_data", bus.i2c_data, e.data);
                        check("exec_grant", bus.grant, (e.port == 1) ? 2'b10 : 2'b01);
                        $display("exec  port=%0d data=%h cycle=%0d", e.port, bus.i2c_data, cyc);
                    end
                end
                dn = {bus.r1_done, bus.r0_done};
                er = {bus.r1_err, bus.r0_err};
                for (int p = 0; p < 2; p++) begin
                    if (dn[p] === 1'b1) begin
                        if (done_q.size() == 0) begin
                            check("done_spurious", dn, 2'b00);
                        end else begin
                            ev_t e;
                            e = done_q.pop_front();
                            check("done_port", p, e.port);
                            check("done_cycle", cyc, e.cyc);
                            check("done_err", er[p], e.err);
                            $display("done  port=%0d err=%0d cycle=%0d", p, er[p], cyc);
                        end
                    end
                end
                if ((er & ~dn) != 2'b00) check("err_without_done", er, 2'b00);
                check("busy", bus.busy, m_active | m_pend[0] | m_pend[1]);
                check("ovf", bus.ovf, m_ovf);
            end
        end
    end

    task automatic pulse(input bit p0, input logic [15:0] d0, input bit p1, input logic [15:0] d1);
        bus.r0_exec = p0; bus.r0_data = d0;
        bus.r1_exec = p1; bus.r1_data = d1;
        @(negedge clk);
        bus.r0_exec = 1'b0;
        bus.r1_exec = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_i2c_exec", bus.i2c_exec, 1'b0);
        check("rst_i2c_data", bus.i2c_data, 16'h0000);
        check("rst_dones", {bus.r1_done, bus.r0_done, bus.r1_err, bus.r0_err}, 4'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ovf", bus.ovf, 2'b00);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(bus.busy === 1'b0 && exec_q.size() == 0 && done_q.size() == 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) expire(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_any_done(output int p);
        int k;
        k = 0;
        p = -1;
        while (p < 0 && k < 100) begin
            @(negedge clk);
            if (bus.r0_done === 1'b1) p = 0;
            else if (bus.r1_done === 1'b1) p = 1;
            k++;
        end
        if (p < 0) expire("wait_done");
    endtask

    initial begin
        int p;
        int k;
        bus.r0_exec = 1'b0; bus.r0_data = 16'd0;
        bus.r1_exec = 1'b0; bus.r1_data = 16'd0;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;

        // single request
        resp_fixed = 17;
        pulse(1'b1, 16'h0201, 1'b0, 16'd0);
        wait_idle("idle_single");

        // tie after reset: port 0 first, then 6A1E
        do_reset();
        resp_fixed = 4;
        pulse(1'b1, 16'h1234, 1'b1, 16'h6A1E);
        wait_idle("idle_tie");

        // fairness: each port re-requests the cycle after its done
        do_reset();
        resp_fixed = 3;
        pulse(1'b1, 16'h0A01, 1'b1, 16'h0B01);
        for (int i = 0; i < 6; i++) begin
            wait_any_done(p);
            if (p >= 0) begin
                @(negedge clk);
                pulse(p == 0, 16'h0A10 + 16'(i), p == 1, 16'h0B10 + 16'(i));
            end
        end
        // re-request in the same cycle as done: dropped
        wait_any_done(p);
        if (p >= 0) pulse(p == 0, 16'hDEAD, p == 1, 16'hBEEF);
        wait_idle("idle_fair");
        check("ovf_same_cycle", bus.ovf != 2'b00, 1'b1);

        // overflow while port 1 is in WAIT
        do_reset();
        resp_fixed = 6;
        pulse(1'b0, 16'd0, 1'b1, 16'h5511);
        k = 0;
        while (bus.i2c_exec !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) expire("wait_exec_ovf");
        pulse(1'b0, 16'd0, 1'b1, 16'h7722);
        wait_idle("idle_ovf");
        check("ovf_port1", bus.ovf, 2'b10);

        // timeout, then a late i2c_done while idle
        do_reset();
        resp_fixed = 12;
        pulse(1'b1, 16'h0C33, 1'b0, 16'd0);
        wait_idle("idle_timeout");
        repeat (6) @(negedge clk);

        // reset in WAIT, late done arrives after reset, then a normal request
        resp_fixed = 6;
        pulse(1'b1, 16'h0E44, 1'b0, 16'd0);
        k = 0;
        while (bus.i2c_exec !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) expire("wait_exec_rst");
        @(negedge clk);
        do_reset();
        repeat (8) @(negedge clk);
        resp_fixed = 2;
        pulse(1'b0, 16'd0, 1'b1, 16'h0F55);
        wait_idle("idle_after_rst");

        // random traffic
        do_reset();
        resp_fixed = -2;
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.r0_exec = ($urandom_range(0, 7) == 0);
            bus.r0_data = 16'($urandom);
            bus.r1_exec = ($urandom_range(0, 7) == 0);
            bus.r1_data = 16'($urandom);
            @(negedge clk);
        end
        bus.r0_exec = 1'b0;
        bus.r1_exec = 1'b0;
        spur_en = 1'b0;
        wait_idle("idle_random");
        check("exec_q_left", exec_q.size(), 0);
        check("done_q_left", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
